// File: rtl/alu_wide_seq.sv
// Nibble-serial sequencer: runs one WIDTH-bit operation on an external 4-bit alu,
// LSB nibble first, with the carry chained through a register between nibbles.
module alu_wide_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic [3:0]       alu_d1,
  output logic [3:0]       alu_d2,
  output logic [4:0]       alu_ctrl,
  input  logic [3:0]       alu_res,
  input  logic             alu_carry_out,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse and
  // result/flags stay valid from done until the next accepted start.

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b11000;
  localparam logic [4:0] OP_COMP  = 5'b01000;
  localparam logic [4:0] OP_RSHFT = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, b_hi, result_q, result_next;
  logic [4:0]         op_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W+1:0]   sh;
  logic               carry_q, illegal_q, chain_cin, final_carry, op_legal;

  function automatic logic is_legal(input logic [4:0] c);
    case (c[3:0])
      4'b0100, 4'b1100, 4'b0101, 4'b0110: return 1'b1;
      default: return (c == OP_ADD) || (c == OP_SUB) || (c == OP_COMP) || (c == OP_RSHFT);
    endcase
  endfunction

  assign op_legal    = is_legal(op);
  assign sh          = {idx_q, 2'b00};
  assign b_hi        = b_q >> 4;
  assign result_next = result_q | ({{(WIDTH-4){1'b0}}, alu_res} << sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = op_legal ? RUN : DONE;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RSHFT feeds the next-higher nibble's LSB in as carry_in; past the top it is 0.
  always_comb begin
    chain_cin   = 1'b0;
    final_carry = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_COMP: begin
        chain_cin   = carry_q;
        final_carry = alu_carry_out;
      end
      OP_RSHFT: begin
        chain_cin   = 1'(b_hi >> sh);
        final_carry = b_q[0];
      end
      default: ;
    endcase
    alu_d1   = 4'd0;
    alu_d2   = 4'd0;
    alu_ctrl = 5'd0;
    if (state_q == RUN) begin
      alu_d1   = 4'(a_q >> sh);
      alu_d2   = 4'(b_q >> sh);
      alu_ctrl = {chain_cin, op_q[3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      illegal_q  <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q       <= a;
          b_q       <= b;
          op_q      <= op;
          idx_q     <= '0;
          result_q  <= '0;
          carry_q   <= (op == OP_SUB);
          illegal_q <= !op_legal;
          if (!op_legal) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b1;
          end
        end
        RUN: begin
          result_q <= result_next;
          carry_q  <= alu_carry_out;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            carry_flag <= final_carry;
            zero_flag  <= (result_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign illegal   = done && illegal_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: doc/alu_wide_seq.md
# alu_wide_seq

Nibble-serial sequencer that executes one WIDTH-bit operation on the 4-bit `alu` datapath. It sits directly upstream of `alu`: it latches a wide command, drives `alu` one nibble per clock (LSB nibble first) and chains the carry between nibbles. It collects the 4-bit results into a WIDTH-bit result with carry and zero flags, and reports completion with a one-cycle `done` pulse.

## Interface
- WIDTH, 16, operand/result width; a multiple of 4 and at least 8; N = WIDTH/4 nibbles
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  5  AluCmd encoding; legal codes are ADD 00000, SUB 11000, COMP 01000, RSHFT 00111, XOR x0100, XNOR x1100, AND x0101, OR x0110
- a  in  WIDTH  first operand; ignored for RSHFT
- b  in  WIDTH  second operand
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- illegal  out  1  high together with `done` when the latched op was not legal
- result  out  WIDTH  registered result; held until the next accepted start
- carry_flag  out  1  registered carry/compare flag
- zero_flag  out  1  result == 0
- alu_d1  out  4  to `alu` d1
- alu_d2  out  4  to `alu` d2
- alu_ctrl  out  5  to `alu` ctrl; bit 4 is the ALU carry_in
- alu_res  in  4  from `alu` res
- alu_carry_out  in  1  from `alu` carry_out

## Operation
- States:
  - IDLE → RUN when start=1 and op is legal.
  - IDLE → DONE when start=1 and op is illegal.
  - RUN → DONE after nibble N-1 is captured.
  - DONE → IDLE unconditionally.
- On an accepted start: latch a, b and op; set nibble index idx=0; clear result.
- In RUN, with k=idx:
  - alu_d1 = a[4k+3:4k] and alu_d2 = b[4k+3:4k], driven from registers.
  - alu_ctrl[3:0] = op[3:0].
  - alu_res is captured into result[4k+3:4k] each cycle, then idx increments.
- alu_ctrl[4] (carry_in) per op:
  - ADD and COMP: 0 at k=0, then the registered alu_carry_out of nibble k-1.
  - SUB: 1 at k=0, then the chained carry.
  - RSHFT: b[4k+4] for k<N-1 and 0 at k=N-1. This gives a logical right shift by 1 and ignores carry_out.
  - XOR, XNOR, AND, OR: 0.
- carry_flag, written on entry to DONE:
  - ADD: final alu_carry_out, i.e. unsigned overflow.
  - SUB: final alu_carry_out; 1 means a ≥ b (no borrow).
  - COMP: final alu_carry_out; 1 means a > b, 0 when a ≤ b.
  - RSHFT: b[0], the bit shifted out.
  - Logic ops: 0.
- zero_flag is computed from the full result on entry to DONE.
- Illegal op: result=0, carry_flag=0, zero_flag=1, illegal=1, and `alu` is never exercised.
- Outside RUN, alu_d1, alu_d2 and alu_ctrl are driven to 0.
- Arithmetic is modulo 2^WIDTH; no sign handling.

## Timing
- Reset values: busy=0, done=0, illegal=0, result=0, carry_flag=0, zero_flag=0, alu_* outputs=0; state=IDLE, idx=0.
- Latency: start sampled at edge E0 → RUN during cycles E0..E(N-1) → done=1 in the cycle after edge EN. For WIDTH=16, done rises 5 edges after start is sampled; back-to-back throughput is N+2 cycles.
- Illegal op: done rises at the first edge after start is sampled.
- start is ignored in RUN and DONE; no queuing.
- result and flags are valid when done=1 and remain stable until the next accepted start.
- Inputs a, b and op may change after the start edge without effect.
- Reset mid-operation asynchronously returns every output to its reset value; the first start after rst_n deasserts is accepted normally.
- Carry chaining is through a register (one nibble per cycle), so `alu` only needs single-cycle combinational timing.

## Test plan
- ADD, WIDTH=16:
  - 0x00FF + 0x0001 → result 0x0100, carry 0, zero 0.
  - 0xFFFF + 0x0001 → result 0x0000, carry 1, zero 1.
  - done pulses exactly 1 cycle, 5 edges after start.
- SUB:
  - 0x1000 − 0x0001 → result 0x0FFF, carry 1.
  - 0x0001 − 0x0002 → result 0xFFFF, carry 0.
  - alu_ctrl[4]=1 in the first RUN cycle.
- COMP:
  - a=0x8000, b=0x7FFF → carry 1.
  - a=0x7FFF, b=0x8000 → carry 0.
  - a=b=0x1234 → carry 0.
- RSHFT and logic ops:
  - RSHFT b=0x8421 → result 0x4210, carry 1.
  - AND 0xF0F0 & 0x3C3C → 0x3030.
  - XNOR a=0, b=0x00FF → 0xFF00.
  - OR 0x0F00 | 0x00F0 → 0x0FF0.
- Protocol:
  - start held high through RUN → exactly one operation runs; busy=1 for 4 cycles.
  - op=00001 → done and illegal pulse 1 edge after start; result 0, zero 1.
- Reset: assert rst_n=0 at idx=2 of an ADD → all outputs 0 immediately; after release, ADD 0x0003 + 0x0004 → 0x0007.
